// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU and its program sequencer.
// Contents: opcode constants, idle bus encoding, sequencer state enum,
//           program word layout and a nibble-to-bus helper.
package cpu_pkg;

  // CPU opcodes. HALT is consumed by the sequencer and never reaches the CPU.
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Value driven on the opcode bus whenever no instruction is in flight.
  localparam logic [7:0] OP_IDLE_BUS = 8'hF0;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_FETCH   = 3'd1,
    SEQ_ISSUE   = 3'd2,
    SEQ_CAPTURE = 3'd3,
    SEQ_FINISH  = 3'd4
  } seq_state_e;

  // One program entry as stored in the sequencer's register file.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] addr;
    logic [3:0] data;
  } prog_word_t;

  // CPU buses carry each 4-bit field in the upper nibble.
  function automatic logic [7:0] nib_to_bus(input logic [3:0] nib);
    return {nib, 4'b0000};
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: DEPTH x W register file.
// Ports: clk, we_i/waddr_i/wdata_i synchronous write port,
//        raddr_i/rdata_o asynchronous (combinational) read port. Not reset.
module seq_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 12
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents deliberately survive reset so a program can be re-run
  // after an aborted execution without reloading it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_program_sequencer.sv
// Host-side initiator for the 4-bit accumulator CPU: steps through a stored
// program, holds each instruction on the CPU buses for SETTLE_CYCLES, then
// captures the accumulator from cpu_result_eightBit[7:4].
// Ports: clk/rst_n; prog_we/prog_addr/prog_word program load (ignored while
//        busy); start/busy/done/pc run control; cpu_*_eightBit and
//        cpu_write_ena to the CPU; result/result_valid captured accumulator.
module cpu_program_sequencer
  import cpu_pkg::*;
#(
  parameter  int SETTLE_CYCLES = 4,
  parameter  int PROG_DEPTH    = 16,
  localparam int PC_W          = $clog2(PROG_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [11:0]     prog_word,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      cpu_opcode_eightBit,
  output logic [7:0]      cpu_addr_eightBit,
  output logic [7:0]      cpu_data_eightBit,
  output logic            cpu_write_ena,
  input  logic [7:0]      cpu_result_eightBit,
  output logic [3:0]      result,
  output logic            result_valid
);

  // Settle counter holds SETTLE_CYCLES-1 down to 0; keep at least one bit.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0]  LAST_PC     = PC_W'(PROG_DEPTH - 1);

  seq_state_e       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] settle_q;
  logic             busy_q;
  logic             done_q;
  logic             result_valid_q;
  logic [3:0]       result_q;
  logic [7:0]       opcode_bus_q;
  logic [7:0]       addr_bus_q;
  logic [7:0]       data_bus_q;
  logic             write_ena_q;

  logic             prog_wr_en;
  logic [11:0]      prog_rd_raw;
  prog_word_t       fetch_word;
  logic             unused_result_lsbs;

  // Loading is locked out for the whole run, including the FINISH cycle.
  // A write in the same cycle as start is allowed and lands before FETCH.
  assign prog_wr_en = prog_we & ~busy_q;

  seq_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (PC_W),
    .W     (12)
  ) u_prog_mem (
    .clk     (clk),
    .we_i    (prog_wr_en),
    .waddr_i (prog_addr),
    .wdata_i (prog_word),
    .raddr_i (pc_q),
    .rdata_o (prog_rd_raw)
  );

  assign fetch_word = prog_word_t'(prog_rd_raw);

  // Only the accumulator nibble of the CPU output is meaningful.
  assign unused_result_lsbs = ^cpu_result_eightBit[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SEQ_IDLE;
      pc_q           <= '0;
      settle_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= 4'h0;
      opcode_bus_q   <= OP_IDLE_BUS;
      addr_bus_q     <= 8'h00;
      data_bus_q     <= 8'h00;
      write_ena_q    <= 1'b0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;

      case (state_q)
        SEQ_IDLE: begin
          if (start) begin
            pc_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= SEQ_FETCH;
          end
        end

        SEQ_FETCH: begin
          if (fetch_word.opcode == OP_HALT) begin
            // HALT ends the run without touching the CPU buses.
            state_q <= SEQ_FINISH;
          end else begin
            opcode_bus_q <= nib_to_bus(fetch_word.opcode);
            addr_bus_q   <= nib_to_bus(fetch_word.addr);
            data_bus_q   <= nib_to_bus(fetch_word.data);
            write_ena_q  <= (fetch_word.opcode == OP_STORE);
            settle_q     <= SETTLE_LOAD;
            state_q      <= SEQ_ISSUE;
          end
        end

        SEQ_ISSUE: begin
          // SETTLE_CYCLES cycles in this state: counts SETTLE_CYCLES-1 .. 0.
          if (settle_q == '0) begin
            state_q <= SEQ_CAPTURE;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end

        SEQ_CAPTURE: begin
          result_q       <= cpu_result_eightBit[7:4];
          result_valid_q <= 1'b1;
          opcode_bus_q   <= OP_IDLE_BUS;
          addr_bus_q     <= 8'h00;
          data_bus_q     <= 8'h00;
          write_ena_q    <= 1'b0;
          // pc never wraps: the last entry terminates the run on its own.
          if (pc_q == LAST_PC) begin
            state_q <= SEQ_FINISH;
          end else begin
            pc_q    <= pc_q + 1'b1;
            state_q <= SEQ_FETCH;
          end
        end

        SEQ_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= SEQ_IDLE;
        end

        default: begin
          state_q <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign pc                  = pc_q;
  assign cpu_opcode_eightBit = opcode_bus_q;
  assign cpu_addr_eightBit   = addr_bus_q;
  assign cpu_data_eightBit   = data_bus_q;
  assign cpu_write_ena       = write_ena_q;
  assign result              = result_q;
  assign result_valid        = result_valid_q;

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Bench for cpu_program_sequencer: CPU stub, whole-run timeline model,
// per-cycle output compare, directed pins and randomized runs.
module tb_cpu_program_sequencer;
  import cpu_pkg::*;

  localparam int S     = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'h0;
  logic [11:0] prog_word = 12'h000;
  logic        start = 1'b0;
  logic        busy, done, cpu_write_ena, result_valid;
  logic [3:0]  pc, result;
  logic [7:0]  cpu_opcode_eightBit, cpu_addr_eightBit, cpu_data_eightBit;
  logic [7:0]  cpu_result_eightBit;

  always #5 clk = ~clk;

  cpu_program_sequencer #(.SETTLE_CYCLES(S), .PROG_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .prog_we             (prog_we),
    .prog_addr           (prog_addr),
    .prog_word           (prog_word),
    .start               (start),
    .busy                (busy),
    .done                (done),
    .pc                  (pc),
    .cpu_opcode_eightBit (cpu_opcode_eightBit),
    .cpu_addr_eightBit   (cpu_addr_eightBit),
    .cpu_data_eightBit   (cpu_data_eightBit),
    .cpu_write_ena       (cpu_write_ena),
    .cpu_result_eightBit (cpu_result_eightBit),
    .result              (result),
    .result_valid        (result_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- CPU behaviour (used by stub and model) ----------------
  function automatic logic [3:0] alu(input logic [3:0] acc, input logic [3:0] op,
                                     input logic [3:0] d, input logic [3:0] mval);
    case (op)
      OP_ADD:  return 4'(acc + d);
      OP_SUB:  return 4'(acc - d);
      OP_LOAD: return mval;
      OP_AND:  return acc & d;
      OP_OR:   return acc | d;
      OP_XOR:  return acc ^ d;
      OP_NOT:  return ~acc;
      OP_SHL:  return 4'(acc << 1);
      OP_SHR:  return acc >> 1;
      default: return acc;
    endcase
  endfunction

  function automatic logic [3:0] dinit(input int i);
    return 4'(i) ^ 4'h5;
  endfunction

  // ---------------- CPU stub ----------------
  logic [3:0] s_acc, s_pend, s_pend_addr, s_noise;
  logic       s_pend_vld, s_pend_st;
  logic [3:0] s_dmem [16];

  always_comb begin
    cpu_result_eightBit = {alu(s_acc, cpu_opcode_eightBit[7:4], cpu_data_eightBit[7:4],
                               s_dmem[cpu_addr_eightBit[7:4]]), s_noise};
  end

  always @(negedge clk) s_noise <= 4'($urandom);

  // The CPU commits an instruction once the sequencer drops it off the bus.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_acc      <= 4'h0;
      s_pend     <= 4'h0;
      s_pend_vld <= 1'b0;
      s_pend_st  <= 1'b0;
      s_pend_addr <= 4'h0;
      for (int i = 0; i < 16; i++) s_dmem[i] <= dinit(i);
    end else if (cpu_opcode_eightBit != OP_IDLE_BUS) begin
      s_pend      <= alu(s_acc, cpu_opcode_eightBit[7:4], cpu_data_eightBit[7:4],
                         s_dmem[cpu_addr_eightBit[7:4]]);
      s_pend_st   <= (cpu_opcode_eightBit[7:4] == OP_STORE) && cpu_write_ena;
      s_pend_addr <= cpu_addr_eightBit[7:4];
      s_pend_vld  <= 1'b1;
    end else if (s_pend_vld) begin
      s_acc      <= s_pend;
      if (s_pend_st) s_dmem[s_pend_addr] <= s_acc;
      s_pend_vld <= 1'b0;
    end
  end

  // ---------------- Timeline model ----------------
  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] pc;
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    logic       we;
    logic [3:0] res;
    logic       rv;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur_exp;
  logic [11:0] m_prog [16];
  logic [3:0] m_dmem [16];
  logic [3:0] m_acc, m_pc, m_res;

  function automatic exp_t idle_exp();
    exp_t e;
    e.busy = 1'b0; e.done = 1'b0; e.pc = m_pc; e.op = 8'hF0; e.addr = 8'h00;
    e.data = 8'h00; e.we = 1'b0; e.res = m_res; e.rv = 1'b0;
    return e;
  endfunction

  // Expands a whole run into the outputs expected after each clock edge.
  task automatic gen_run();
    exp_t e;
    logic [3:0] op, a, d;
    e = idle_exp();
    e.busy = 1'b1;
    e.pc   = 4'h0;
    exp_q.push_back(e);
    for (int i = 0; i < DEPTH; i++) begin
      op = m_prog[i][11:8]; a = m_prog[i][7:4]; d = m_prog[i][3:0];
      e.pc = 4'(i);
      e.rv = 1'b0;
      if (op == OP_HALT) begin
        exp_q.push_back(e);
        e.busy = 1'b0; e.done = 1'b1;
        exp_q.push_back(e);
        m_pc = 4'(i); m_res = e.res;
        return;
      end
      e.op = {op, 4'h0}; e.addr = {a, 4'h0}; e.data = {d, 4'h0};
      e.we = (op == OP_STORE);
      repeat (S + 1) exp_q.push_back(e);
      if (op == OP_STORE) m_dmem[a] = m_acc;
      else m_acc = alu(m_acc, op, d, m_dmem[a]);
      e.res = m_acc; e.rv = 1'b1;
      e.op = 8'hF0; e.addr = 8'h00; e.data = 8'h00; e.we = 1'b0;
      e.pc = (i == DEPTH - 1) ? 4'(i) : 4'(i + 1);
      exp_q.push_back(e);
    end
    e.rv = 1'b0; e.busy = 1'b0; e.done = 1'b1;
    exp_q.push_back(e);
    m_pc = 4'(DEPTH - 1); m_res = e.res;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 4'h0; m_pc = 4'h0; m_res = 4'h0;
      for (int i = 0; i < 16; i++) m_dmem[i] = dinit(i);
      cur_exp = idle_exp();
    end else if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
    end else begin
      // Empty timeline means the sequencer is idle before this edge.
      if (prog_we) m_prog[prog_addr] = prog_word;
      if (start) begin
        gen_run();
        cur_exp = exp_q.pop_front();
      end else begin
        cur_exp = idle_exp();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",         {31'd0, busy},          {31'd0, cur_exp.busy});
      check("done",         {31'd0, done},          {31'd0, cur_exp.done});
      check("pc",           {28'd0, pc},            {28'd0, cur_exp.pc});
      check("opcode_bus",   {24'd0, cpu_opcode_eightBit}, {24'd0, cur_exp.op});
      check("addr_bus",     {24'd0, cpu_addr_eightBit},   {24'd0, cur_exp.addr});
      check("data_bus",     {24'd0, cpu_data_eightBit},   {24'd0, cur_exp.data});
      check("write_ena",    {31'd0, cpu_write_ena}, {31'd0, cur_exp.we});
      check("result",       {28'd0, result},        {28'd0, cur_exp.res});
      check("result_valid", {31'd0, result_valid},  {31'd0, cur_exp.rv});
    end
  end

  // ---------------- Stimulus helpers ----------------
  typedef struct {
    int         rv_cyc;
    int         rv_cnt;
    int         we_cnt;
    int         bus_cnt;
    int         done_cyc;
    logic [3:0] first_res;
    logic [3:0] last_res;
    logic [3:0] done_pc;
  } watch_t;

  task automatic wr(input logic [3:0] a, input logic [11:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_word = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Pulses start and records what happens; cycle c = outputs after start edge + c.
  task automatic run_watch(output watch_t w);
    w.rv_cyc = -1; w.rv_cnt = 0; w.we_cnt = 0; w.bus_cnt = 0; w.done_cyc = -1;
    w.first_res = 4'h0; w.last_res = 4'h0; w.done_pc = 4'h0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (result_valid) begin
        if (w.rv_cnt == 0) begin w.rv_cyc = c; w.first_res = result; end
        w.rv_cnt++;
        w.last_res = result;
      end
      if (cpu_write_ena) w.we_cnt++;
      if (cpu_opcode_eightBit != 8'hF0) w.bus_cnt++;
      if (done) begin w.done_cyc = c; w.done_pc = pc; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_opcode"}, {24'd0, cpu_opcode_eightBit}, 32'hF0);
    check({tag, "_addr"},   {24'd0, cpu_addr_eightBit},   32'h00);
    check({tag, "_data"},   {24'd0, cpu_data_eightBit},   32'h00);
    check({tag, "_busy"},   {31'd0, busy},                32'd0);
    check({tag, "_done"},   {31'd0, done},                32'd0);
    check({tag, "_pc"},     {28'd0, pc},                  32'd0);
    check({tag, "_result"}, {28'd0, result},              32'd0);
    check({tag, "_rv"},     {31'd0, result_valid},        32'd0);
    check({tag, "_we"},     {31'd0, cpu_write_ena},       32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // ---------------- Test sequence ----------------
  initial begin
    watch_t w;
    int     dcnt;
    int     n;

    for (int i = 0; i < 16; i++) m_prog[i] = 12'h000;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // LOAD from addr 2 (CPU memory holds 2^5 = 7 there), then HALT
    wr(4'd0, 12'h320);
    wr(4'd1, 12'hF00);
    run_watch(w);
    check("load_rv_cycle",  w.rv_cyc,   32'd6);
    check("load_result",    {28'd0, w.first_res}, 32'h7);
    check("load_rv_count",  w.rv_cnt,   32'd1);
    check("load_bus_cycles", w.bus_cnt, S + 1);
    check("load_we_cycles", w.we_cnt,   32'd0);
    check("load_done_cycle", w.done_cyc, 32'd8);
    @(negedge clk);
    check("load_busy_after", {31'd0, busy}, 32'd0);

    // STORE acc (7) to addr 5, LOAD it back, HALT
    wr(4'd0, 12'h250);
    wr(4'd1, 12'h350);
    wr(4'd2, 12'hF00);
    run_watch(w);
    check("store_we_cycles", w.we_cnt,  S + 1);
    check("store_rv_count",  w.rv_cnt,  32'd2);
    check("store_first_res", {28'd0, w.first_res}, 32'h7);
    check("store_loadback",  {28'd0, w.last_res},  32'h7);
    check("store_bus_cycles", w.bus_cnt, 2 * (S + 1));

    // HALT at entry 0
    wr(4'd0, 12'hF00);
    run_watch(w);
    check("halt0_done_cycle", w.done_cyc, 32'd2);
    check("halt0_rv_count",   w.rv_cnt,   32'd0);
    check("halt0_bus_cycles", w.bus_cnt,  32'd0);

    // Sixteen ADD 1 with no HALT, from a cleared accumulator
    pulse_reset();
    for (int i = 0; i < 16; i++) wr(4'(i), 12'h001);
    run_watch(w);
    check("add16_rv_count",  w.rv_cnt,   32'd16);
    check("add16_first_res", {28'd0, w.first_res}, 32'h1);
    check("add16_last_res",  {28'd0, w.last_res},  32'h0);
    check("add16_done_cyc",  w.done_cyc, 16 * (S + 2) + 1);
    check("add16_done_pc",   {28'd0, w.done_pc},   32'hF);

    // Reset during ISSUE of entry 3
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(pc == 4'd3 && cpu_opcode_eightBit != 8'hF0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrun_reached_entry3", {28'd0, pc}, 32'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Restart: program intact; a write attempted while busy must be dropped
    fork
      run_watch(w);
      begin
        repeat (10) @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_word = 12'hF00;
        @(negedge clk);
        prog_we = 1'b0;
      end
    join
    check("restart_rv_count", w.rv_cnt,  32'd16);
    check("restart_last_res", {28'd0, w.last_res}, 32'h0);
    run_watch(w);
    check("busy_write_ignored", w.rv_cnt, 32'd16);

    // Start held high: back-to-back HALT runs, one IDLE cycle apart
    wr(4'd0, 12'hF00);
    @(negedge clk);
    start = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("held_start_done_count", dcnt, 32'd3);

    // Randomized programs, starts and loads
    for (int r = 0; r < 30; r++) begin
      wait_idle();
      for (int i = 0; i < 16; i++)
        wr(4'(i), {4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom)});
      for (int c = 0; c < 120; c++) begin
        @(negedge clk);
        start     = ($urandom_range(0, 3) == 0);
        prog_we   = ($urandom_range(0, 5) == 0);
        prog_addr = 4'($urandom);
        prog_word = 12'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
      wait_idle();
      if (r == 15) pulse_reset();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_program_sequencer.md
Name: cpu_program_sequencer

Overview:
Host-side initiator for the 4-bit accumulator CPU. It holds a 16-entry instruction program and issues each instruction on the CPU's 8-bit opcode, address and data buses, with each 4-bit field in the MSB nibble. It waits a fixed settle time per instruction, then captures the accumulator from the CPU's 8-bit output (MSB nibble). It sits between the chip-level control pins and the CPU core and forms the driving end of the CPU's instruction interface.

Parameters:
SETTLE_CYCLES, 4, cycles an instruction is held on the CPU buses before the result is sampled (min 1)
PROG_DEPTH, 16, program entries; pc is $clog2(PROG_DEPTH) bits wide

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
prog_we  input  1  program write strobe; ignored while busy
prog_addr  input  4  program entry index
prog_word  input  12  {opcode[11:8], addr[7:4], data[3:0]}
start  input  1  begin execution at entry 0; ignored while busy
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at end of program
pc  output  4  index of the instruction currently in flight
cpu_opcode_eightBit  output  8  {opcode, 4'b0000}
cpu_addr_eightBit  output  8  {addr, 4'b0000}
cpu_data_eightBit  output  8  {data, 4'b0000}
cpu_write_ena  output  1  high only while a STORE is issued
cpu_result_eightBit  input  8  CPU output; bits [7:4] hold the accumulator
result  output  4  last captured accumulator value
result_valid  output  1  one-cycle pulse when result updates

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low; all sequential logic is asynchronously cleared when rst_n=0.
- Reset values: busy=0, done=0, pc=0, result=0, result_valid=0, cpu_write_ena=0, cpu_addr/data_eightBit=8'h00, cpu_opcode_eightBit=8'hF0 (idle opcode). Program memory is not reset.
- Opcodes: 0000 ADD, 0001 SUB, 0010 STORE, 0011 LOAD, 0101 AND, 0110 OR, 0111 XOR, 1000 NOT, 1001 SHL, 1010 SHR, 1111 HALT. HALT is sequencer-only and is never issued to the CPU. Any other code is issued unchanged.
- Program write: on a clk edge with prog_we=1 and busy=0, mem[prog_addr] <= prog_word.
- FSM states: IDLE, FETCH, ISSUE, CAPTURE, FINISH.
  - IDLE: start=1 -> pc<=0, busy<=1, go to FETCH.
  - FETCH: read mem[pc]. If opcode==HALT -> FINISH. Otherwise latch the fields onto the CPU buses, set cpu_write_ena=(opcode==STORE), load settle counter with SETTLE_CYCLES-1, go to ISSUE.
  - ISSUE: hold the buses stable. Decrement the counter; at 0 go to CAPTURE.
  - CAPTURE: result<=cpu_result_eightBit[7:4] and result_valid=1 for this cycle. Drive opcode back to 8'hF0, write_ena=0 and addr/data=0. If pc==PROG_DEPTH-1 -> FINISH; otherwise pc<=pc+1 and go to FETCH.
  - FINISH: done=1 for one cycle, busy<=0, go to IDLE. pc holds its last value.
- Per-instruction latency: 1 (FETCH) + SETTLE_CYCLES (ISSUE) + 1 (CAPTURE) = SETTLE_CYCLES+2 cycles. Buses are stable for SETTLE_CYCLES+1 edges, counting from the FETCH edge.
- Boundaries:
  - pc does not wrap. Reaching the last entry without a HALT ends the run via FINISH.
  - HALT at entry 0 gives done two cycles after start, with no result_valid.
  - start and prog_we in the same cycle while IDLE: the write completes and the run begins; entry written this cycle is visible in FETCH.
  - start held high: a run is re-armed only from IDLE, so continuous start gives back-to-back runs with one IDLE cycle between them.
  - Reset mid-run: all outputs return to their reset values immediately (async), the run is abandoned and the program contents are retained.

Decomposition:
- Shared package cpu_pkg: opcode localparams (OP_ADD..OP_SHR, OP_HALT=4'hF, OP_IDLE_BUS=8'hF0) and the sequencer state enum.
- The CPU core uses the same opcode constants.
- One sub-module, seq_prog_mem: 16x12 synchronous-write, asynchronous-read register file.

Test Plan:
- Reset: hold rst_n=0 -> opcode_eightBit=8'hF0, busy=0, pc=0, result=0.
- Write prog {0x3_2_0, 0xF_0_0} and start -> opcode bus 8'h30 and addr 8'h20 held 4 cycles. result=CPU accumulator with result_valid at cycle 6, then done; busy low after.
- STORE entry 0x2_5_0 -> cpu_write_ena=1 exactly for FETCH+ISSUE of that entry, 0 otherwise.
- 16 entries of ADD 0x0_0_1, no HALT, against the CPU model -> 16 result_valid pulses with results 1..0 (mod 16), then done at pc=15.
- HALT at entry 0 -> done two cycles after start; no bus activity and no result_valid.
- Assert rst_n=0 during ISSUE of entry 3 -> outputs reset asynchronously. A restart after release re-runs from entry 0 with the program intact. prog_we while busy leaves mem unchanged.
